// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Column and row buses are limited to KP_ONEHOT_MAX lines by the one-hot helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HELD
    } kp_state_t;

    localparam int KP_ONEHOT_MAX = 32;

    // Key code width: enough bits for N_ROWS*N_COLS codes, never less than one.
    function automatic int kp_kw(input int n_rows, input int n_cols);
        return (n_rows * n_cols > 1) ? $clog2(n_rows * n_cols) : 1;
    endfunction

    function automatic logic [KP_ONEHOT_MAX-1:0] onehot(input int idx, input int width);
        logic [KP_ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx >= 0 && idx < width) begin
            v = KP_ONEHOT_MAX'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/keypad_repeat_timer.sv
// Auto-repeat timer: counts held cycles and flags the cycle before each repeat strobe,
// so the scanner's registered key_valid lands on HELD cycle DELAY, DELAY+PERIOD, ...
module keypad_repeat_timer #(
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic clk_div,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(MAXV + 2);
    localparam logic [TW-1:0] DELAY_T  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] PERIOD_T = TW'(REPEAT_PERIOD);

    logic [TW-1:0] cnt_reg;
    logic          first_reg;
    logic [TW-1:0] target;

    // cnt_reg equals the current HELD cycle number during the first interval.
    assign target = first_reg ? DELAY_T : PERIOD_T;
    assign tick   = enable && !clear && ((cnt_reg + TW'(1)) == target);

    always_ff @(posedge clk_div) begin
        if (rst) begin
            cnt_reg   <= '0;
            first_reg <= 1'b1;
        end else if (clear) begin
            cnt_reg   <= TW'(1);
            first_reg <= 1'b1;
        end else if (enable) begin
            if (tick) begin
                cnt_reg   <= '0;
                first_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + TW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix keypad scanner with whole-scan debounce, ghost rejection,
// release detection and optional auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int RELEASE_CYCLES = 4,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_PERIOD  = 16,
    localparam int KW            = kp_kw(N_ROWS, N_COLS)
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic [N_ROWS-1:0] sync_row,
    output logic [N_COLS-1:0] col,
    output logic [KW-1:0]     key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_release,
    output logic              multi_key
);

    localparam int CW = $clog2(N_COLS + 1);
    localparam int RW = $clog2(N_ROWS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int LW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(N_COLS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_DONE    = DW'(DEBOUNCE_SCANS);
    localparam logic [LW-1:0] REL_DONE    = LW'(RELEASE_CYCLES);

    kp_state_t     state_reg;
    logic [N_COLS-1:0] col_reg;
    logic [KW-1:0] key_code_reg;
    logic          key_valid_reg, key_held_reg, key_release_reg, multi_key_reg;
    logic [CW-1:0] col_idx_reg;
    logic [SW-1:0] settle_reg;
    logic          cand_valid_reg, multi_reg;
    logic [RW-1:0] cand_row_reg, prev_row_reg, held_row_reg;
    logic [CW-1:0] cand_col_reg, prev_col_reg;
    logic [DW-1:0] deb_reg;
    logic [LW-1:0] rel_reg;

    logic          row_any, row_many, row_one;
    logic [RW-1:0] row_idx;
    logic          sample_now, multi_now, cand_now, same_as_prev;
    logic [RW-1:0] cand_row_now;
    logic [CW-1:0] cand_col_now;
    logic          accept, held_en, held_hit, rep_tick;
    logic [N_COLS-1:0] oh_first, oh_step, oh_prev_col;
    logic [N_ROWS-1:0] oh_held_row;

    assign col         = col_reg;
    assign key_code    = key_code_reg;
    assign key_valid   = key_valid_reg;
    assign key_held    = key_held_reg;
    assign key_release = key_release_reg;
    assign multi_key   = multi_key_reg;

    // Classify the row sample as none / exactly one / several, keeping the set row index.
    always_comb begin
        row_any  = 1'b0;
        row_many = 1'b0;
        row_idx  = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            if (sync_row[i]) begin
                row_many = row_many | row_any;
                row_any  = 1'b1;
                row_idx  = RW'(i);
            end
        end
    end

    assign oh_first    = N_COLS'(onehot(0, N_COLS));
    assign oh_step     = N_COLS'(onehot(int'(col_idx_reg) + 1, N_COLS));
    assign oh_prev_col = N_COLS'(onehot(int'(prev_col_reg), N_COLS));
    assign oh_held_row = N_ROWS'(onehot(int'(held_row_reg), N_ROWS));

    assign row_one      = row_any & ~row_many;
    assign sample_now   = (settle_reg == LAST_SETTLE);
    assign multi_now    = multi_reg | row_many | (row_one & cand_valid_reg);
    assign cand_now     = cand_valid_reg | row_one;
    assign cand_row_now = cand_valid_reg ? cand_row_reg : row_idx;
    assign cand_col_now = cand_valid_reg ? cand_col_reg : col_idx_reg;
    assign same_as_prev = (cand_row_now == prev_row_reg) && (cand_col_now == prev_col_reg);
    assign held_hit     = |(sync_row & oh_held_row);
    assign held_en      = (state_reg == HELD);

    // The debounce count is judged on its registered value in the first cycle of the
    // following scan; that cycle is given up to move into HELD.
    assign accept = (state_reg == SCAN) && (col_idx_reg == '0) && (settle_reg == '0)
                    && (deb_reg == DEB_DONE);

    generate
        if (REPEAT_EN != 0) begin : g_rep
            keypad_repeat_timer #(
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_repeat (
                .clk_div (clk_div),
                .rst     (rst),
                .enable  (held_en),
                .clear   (accept),
                .tick    (rep_tick)
            );
        end else begin : g_norep
            assign rep_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_reg       <= IDLE;
            col_reg         <= '1;
            key_code_reg    <= '0;
            key_valid_reg   <= 1'b0;
            key_held_reg    <= 1'b0;
            key_release_reg <= 1'b0;
            multi_key_reg   <= 1'b0;
            col_idx_reg     <= '0;
            settle_reg      <= '0;
            cand_valid_reg  <= 1'b0;
            multi_reg       <= 1'b0;
            cand_row_reg    <= '0;
            cand_col_reg    <= '0;
            prev_row_reg    <= '0;
            prev_col_reg    <= '0;
            held_row_reg    <= '0;
            deb_reg         <= '0;
            rel_reg         <= '0;
        end else begin
            key_valid_reg   <= 1'b0;
            key_release_reg <= 1'b0;
            multi_key_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    col_reg <= '1;
                    if (|sync_row) begin
                        state_reg      <= SCAN;
                        col_idx_reg    <= '0;
                        settle_reg     <= '0;
                        cand_valid_reg <= 1'b0;
                        multi_reg      <= 1'b0;
                        col_reg        <= oh_first;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        state_reg     <= HELD;
                        key_code_reg  <= KW'(int'(prev_row_reg) * N_COLS + int'(prev_col_reg));
                        key_valid_reg <= 1'b1;
                        key_held_reg  <= 1'b1;
                        held_row_reg  <= prev_row_reg;
                        col_reg       <= oh_prev_col;
                        rel_reg       <= '0;
                        deb_reg       <= '0;
                    end else if (!sample_now) begin
                        settle_reg <= settle_reg + SW'(1);
                    end else if (col_idx_reg != LAST_COL) begin
                        settle_reg     <= '0;
                        col_idx_reg    <= col_idx_reg + CW'(1);
                        col_reg        <= oh_step;
                        multi_reg      <= multi_now;
                        cand_valid_reg <= cand_now;
                        cand_row_reg   <= cand_row_now;
                        cand_col_reg   <= cand_col_now;
                    end else begin
                        settle_reg     <= '0;
                        col_idx_reg    <= '0;
                        cand_valid_reg <= 1'b0;
                        multi_reg      <= 1'b0;
                        if (multi_now) begin
                            multi_key_reg <= 1'b1;
                            deb_reg       <= '0;
                            state_reg     <= IDLE;
                            col_reg       <= '1;
                        end else if (!cand_now) begin
                            deb_reg   <= '0;
                            state_reg <= IDLE;
                            col_reg   <= '1;
                        end else begin
                            deb_reg      <= same_as_prev ? deb_reg + DW'(1) : DW'(1);
                            prev_row_reg <= cand_row_now;
                            prev_col_reg <= cand_col_now;
                            col_reg      <= oh_first;
                        end
                    end
                end
                HELD: begin
                    if (rel_reg == REL_DONE) begin
                        key_release_reg <= 1'b1;
                        key_held_reg    <= 1'b0;
                        state_reg       <= IDLE;
                        col_reg         <= '1;
                        rel_reg         <= '0;
                    end else begin
                        rel_reg <= held_hit ? '0 : rel_reg + LW'(1);
                        if (rep_tick) begin
                            key_valid_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    col_reg   <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: default 4x4, auto-repeat and 2x3 instances
// driven from a simple keypad model (row = OR of pressed keys on the driven columns).
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] row_a, col_a, code_a;
    logic       kv_a, kh_a, kr_a, mk_a;
    logic [3:0] pm_a [4];

    logic [3:0] row_r, col_r, code_r;
    logic       kv_r, kh_r, kr_r, mk_r;
    logic [3:0] pm_r [4];

    logic [1:0] row_n;
    logic [2:0] col_n, code_n;
    logic       kv_n, kh_n, kr_n, mk_n;
    logic [2:0] pm_n [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            row_a[i] = |(col_a & pm_a[i]);
            row_r[i] = |(col_r & pm_r[i]);
        end
        for (int i = 0; i < 2; i++) begin
            row_n[i] = |(col_n & pm_n[i]);
        end
    end

    keypad_scanner dut_a (
        .clk_div(clk), .rst(rst), .sync_row(row_a), .col(col_a), .key_code(code_a),
        .key_valid(kv_a), .key_held(kh_a), .key_release(kr_a), .multi_key(mk_a)
    );

    keypad_scanner #(.REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut_r (
        .clk_div(clk), .rst(rst), .sync_row(row_r), .col(col_r), .key_code(code_r),
        .key_valid(kv_r), .key_held(kh_r), .key_release(kr_r), .multi_key(mk_r)
    );

    keypad_scanner #(.N_ROWS(2), .N_COLS(3)) dut_n (
        .clk_div(clk), .rst(rst), .sync_row(row_n), .col(col_n), .key_code(code_n),
        .key_valid(kv_n), .key_held(kh_n), .key_release(kr_n), .multi_key(mk_n)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0: return kv_a;
            1: return kr_a;
            2: return mk_a;
            3: return kv_r;
            4: return kr_r;
            5: return kv_n;
            6: return kr_n;
            default: return 1'b0;
        endcase
    endfunction

    // Counts rising edges until the selected strobe is seen; returns limit on timeout.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!probe(sel) && n < limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int first;
        int cnt;
        logic exp_v;

        for (int i = 0; i < 4; i++) begin
            pm_a[i] = '0;
            pm_r[i] = '0;
        end
        pm_n[0] = '0;
        pm_n[1] = '0;

        rst = 1'b1;
        repeat (3) step();
        check("rst_col", col_a, 4'hf);
        check("rst_code", code_a, 0);
        check("rst_strobes", {kv_a, kh_a, kr_a, mk_a}, 0);
        check("rst_col_n", col_n, 3'h7);
        rst = 1'b0;
        step();

        // Reset in the middle of a scan
        pm_a[0] = 4'b0001;
        repeat (6) step();
        check("midscan_col", col_a, 4'b0100);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_col", col_a, 4'hf);
            check("midrst_strobes", {kv_a, kh_a, kr_a, mk_a}, 0);
        end
        rst = 1'b0;
        step();
        check("post_rst_scan", col_a, 4'b0001);
        pm_a[0] = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (kv_a) cnt++;
        end
        check("post_rst_novalid", cnt, 0);
        check("post_rst_idle", col_a, 4'hf);

        // Clean press row2/col1
        pm_a[2] = 4'b0010;
        wait_for(0, 60, n);
        check("press_latency", n, 26);
        check("press_code", code_a, 9);
        check("press_held", kh_a, 1);
        check("press_col", col_a, 4'b0010);
        step();
        check("press_strobe_1cyc", kv_a, 0);
        check("press_held_stays", kh_a, 1);
        pm_a[2] = 4'b0000;
        wait_for(1, 20, n);
        check("release_latency", n, 5);
        check("release_held_low", kh_a, 0);
        check("release_col_idle", col_a, 4'hf);
        step();
        check("release_strobe_1cyc", kr_a, 0);
        repeat (4) step();

        // Bounce: key lost at the last column of the second scan, then stable
        pm_a[1] = 4'b1000;
        first = 0;
        cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (kv_a) begin
                if (first == 0) first = i;
                cnt++;
            end
            if (i == 15) pm_a[1] = 4'b0000;
            if (i == 18) pm_a[1] = 4'b1000;
        end
        check("bounce_latency", first, 44);
        check("bounce_single_valid", cnt, 1);
        check("bounce_code", code_a, 7);
        pm_a[1] = 4'b0000;
        wait_for(1, 20, n);
        check("bounce_release", n, 5);
        repeat (4) step();

        // Ghost: rows 0 and 1 both on column 0
        pm_a[0] = 4'b0001;
        pm_a[1] = 4'b0001;
        wait_for(2, 30, n);
        check("ghost_multi_latency", n, 9);
        check("ghost_idle", col_a, 4'hf);
        step();
        check("ghost_strobe_1cyc", mk_a, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (kv_a) cnt++;
        end
        check("ghost_novalid", cnt, 0);
        pm_a[0] = 4'b0000;
        pm_a[1] = 4'b0000;
        repeat (20) step();

        // Ghost across columns: (0,0) and (1,1)
        pm_a[0] = 4'b0001;
        pm_a[1] = 4'b0010;
        wait_for(2, 30, n);
        check("ghost2_multi_latency", n, 9);
        check("ghost2_novalid", {kv_a, kh_a}, 0);
        pm_a[0] = 4'b0000;
        pm_a[1] = 4'b0000;
        repeat (20) step();

        // Auto-repeat on key 0
        pm_r[0] = 4'b0001;
        wait_for(3, 60, n);
        check("rep_latency", n, 26);
        check("rep_code", code_r, 0);
        check("rep_held", kh_r, 1);
        for (int h = 2; h <= 20; h++) begin
            step();
            exp_v = (h == 8 || h == 12 || h == 16 || h == 20);
            check($sformatf("rep_valid_h%0d", h), kv_r, exp_v);
            if (exp_v) check($sformatf("rep_code_h%0d", h), code_r, 0);
        end
        pm_r[0] = 4'b0000;
        wait_for(4, 20, n);
        check("rep_release", n, 5);
        check("rep_held_low", kh_r, 0);

        // Non-square 2x3: row1/col2
        pm_n[1] = 3'b100;
        wait_for(5, 60, n);
        check("ns_latency", n, 20);
        check("ns_code", code_n, 5);
        check("ns_held", kh_n, 1);
        pm_n[1] = 3'b000;
        wait_for(6, 20, n);
        check("ns_release", n, 5);
        repeat (5) step();

        // Short press: released after one scan
        pm_n[1] = 3'b100;
        repeat (7) step();
        pm_n[1] = 3'b000;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (kv_n) cnt++;
        end
        check("ns_short_novalid", cnt, 0);
        check("ns_short_notheld", kh_n, 0);
        check("ns_short_idle", col_n, 3'h7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
